// File: rtl/set_bit_enumerator_pkg.sv
// rtl/set_bit_enumerator_pkg.sv - shared constants, FSM state type and popcount helper
//
// Contents:
//   WIDTH, IDXW, CNTW : vector, index/ordinal and popcount widths
//   state_e           : IDLE (accepting a vector) / EMIT (streaming indices)
//   popcount()        : number of set bits in a WIDTH-bit vector
package set_bit_enumerator_pkg;

  localparam int WIDTH = 32;
  localparam int IDXW  = 5;
  localparam int CNTW  = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // CNTW is one bit wider than IDXW so an all-ones vector (32) fits.
  function automatic logic [CNTW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CNTW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/set_bit_enumerator_ffs_enc.sv
// rtl/set_bit_enumerator_ffs_enc.sv - combinational lowest-set-bit priority encoder
//
// Ports:
//   vec    in  WIDTH  vector to search
//   idx    out IDXW   position of the lowest set bit (0 when vec is zero)
//   any    out 1      vec has at least one bit set
//   onehot out WIDTH  isolated lowest set bit (all-zero when vec is zero)
module ffs_enc
  import set_bit_enumerator_pkg::*;
(
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             any,
  output logic [WIDTH-1:0] onehot
);

  // Two's-complement trick: vec & -vec keeps only the lowest set bit.
  assign onehot = vec & (~vec + WIDTH'(1));
  assign any    = |vec;

  // Scan from the top so the lowest set bit wins the last assignment.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/set_bit_enumerator.sv
// rtl/set_bit_enumerator.sv - expands a 32-bit vector into a stream of set-bit indices
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready      vector handshake; in_vec is the vector to enumerate
//   out_valid/out_ready    beat handshake, one beat per set bit (one beat if empty)
//   out_idx                position of the current set bit, ascending
//   out_seq                0-based ordinal of the beat within the vector
//   out_count              popcount of the whole vector, constant across its beats
//   out_last               final beat of the vector
//   out_empty              vector was all-zero (single beat, idx 0)
module set_bit_enumerator
  import set_bit_enumerator_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic [IDXW-1:0]  out_seq,
  output logic [CNTW-1:0]  out_count,
  output logic             out_last,
  output logic             out_empty
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [IDXW-1:0]  seq_q, seq_d;
  logic             empty_q, empty_d;

  logic [IDXW-1:0]  ffs_idx;
  logic             ffs_any;
  logic [WIDTH-1:0] ffs_onehot;

  logic emit;
  logic last_beat;
  logic accept;
  logic beat;

  ffs_enc u_ffs_enc (
    .vec    (mask_q),
    .idx    (ffs_idx),
    .any    (ffs_any),
    .onehot (ffs_onehot)
  );

  assign emit = (state_q == EMIT);

  // Last beat: the mask holds only the bit being emitted now, or the
  // vector was empty and this is its only beat.
  assign last_beat = empty_q || (ffs_any && ((mask_q & ~ffs_onehot) == '0));

  assign accept = !emit && in_valid;
  assign beat   = emit && out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    seq_d   = seq_q;
    empty_d = empty_q;

    if (accept) begin
      state_d = EMIT;
      mask_d  = in_vec;
      count_d = popcount(in_vec);
      seq_d   = '0;
      empty_d = (in_vec == '0);
    end else if (beat) begin
      mask_d = mask_q & ~ffs_onehot;
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        // Only advanced between beats, so 32 beats never wrap the ordinal.
        seq_d = seq_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      count_q <= '0;
      seq_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      seq_q   <= seq_d;
      empty_q <= empty_d;
    end
  end

  // Outputs come only from registered state; they read as zero in IDLE.
  assign in_ready  = !emit;
  assign out_valid = emit;
  assign out_idx   = emit ? ffs_idx : '0;
  assign out_seq   = emit ? seq_q : '0;
  assign out_count = emit ? count_q : '0;
  assign out_last  = emit && last_beat;
  assign out_empty = emit && empty_q;

endmodule
